// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared encodings for the data-memory access stage:
//   - store size encoding driven on me_writeMem
//   - load type encoding driven on me_readMem
//   - state encoding of the dmem_access bus FSM
//   - helpers that classify an access (valid load, misaligned access)
// -----------------------------------------------------------------------------
package mem_pkg;

    // Store size (me_writeMem)
    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_BYTE = 2'b01,
        ST_HALF = 2'b10,
        ST_WORD = 2'b11
    } st_size_e;

    // Load type (me_readMem); 3'b110 and 3'b111 are not loads
    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_LB   = 3'b001,
        LD_LH   = 3'b010,
        LD_LW   = 3'b011,
        LD_LBU  = 3'b100,
        LD_LHU  = 3'b101
    } ld_type_e;

    // Bus FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // True for the five real load encodings only
    function automatic logic ld_valid(input logic [2:0] ld_type);
        logic v;
        case (ld_type)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: v = 1'b1;
            default:                             v = 1'b0;
        endcase
        return v;
    endfunction

    // Misalignment of the access that will actually be performed.
    // A store takes precedence, so the load type is only examined when
    // no store is requested. Byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] st_size,
                                           input logic [2:0] ld_type,
                                           input logic [1:0] offset);
        logic m;
        m = 1'b0;
        if (st_size != ST_NONE) begin
            case (st_size)
                ST_HALF: m = offset[0];
                ST_WORD: m = (offset != 2'b00);
                default: m = 1'b0;
            endcase
        end else begin
            case (ld_type)
                LD_LH, LD_LHU: m = offset[0];
                LD_LW:         m = (offset != 2'b00);
                default:       m = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_access_if.sv
// -----------------------------------------------------------------------------
// dmem_access_if
// Data-memory bus between the access stage (master) and the memory
// responder (slave).
//   dmem_req    master->slave  request valid, held until ack or abort
//   dmem_we     master->slave  write enable
//   dmem_addr   master->slave  word-aligned byte address
//   dmem_wdata  master->slave  lane-replicated store data
//   dmem_wstrb  master->slave  byte-lane strobes
//   dmem_ack    slave->master  completion, qualifies dmem_rdata
//   dmem_rdata  slave->master  read word
// -----------------------------------------------------------------------------
interface dmem_access_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/dmem_format.sv
// -----------------------------------------------------------------------------
// dmem_format
// Purely combinational lane handling for the data-memory access stage.
//   i_st_size    store size (ST_*), ST_NONE gives zero data and strobes
//   i_st_offset  byte offset of the store within its word
//   i_st_data    store data, right-aligned
//   i_ld_type    load type (LD_*), anything else formats to zero
//   i_ld_offset  byte offset of the load within its word
//   i_rdata      read word returned by memory
//   o_wdata      store data replicated across every lane it may occupy
//   o_wstrb      byte strobes selecting the written lanes
//   o_ld_data    extracted and sign/zero-extended load result
// -----------------------------------------------------------------------------
module dmem_format
    import mem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_offset,
    input  logic [31:0] i_st_data,
    input  logic [2:0]  i_ld_type,
    input  logic [1:0]  i_ld_offset,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_ld_data
);

    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;

    // Store path: data is replicated so the strobes alone pick the lane
    always_comb begin
        o_wdata = '0;
        o_wstrb = '0;
        case (i_st_size)
            ST_BYTE: begin
                o_wstrb = 4'b0001 << i_st_offset;
                o_wdata = {4{i_st_data[7:0]}};
            end
            ST_HALF: begin
                o_wstrb = 4'b0011 << {i_st_offset[1], 1'b0};
                o_wdata = {2{i_st_data[15:0]}};
            end
            ST_WORD: begin
                o_wstrb = 4'b1111;
                o_wdata = i_st_data;
            end
            default: begin
                o_wstrb = '0;
                o_wdata = '0;
            end
        endcase
    end

    // Load path: pick the lane, then extend according to the load type
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_ld_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase

        w_half = i_ld_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_ld_data = '0;
        case (i_ld_type)
            LD_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            LD_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            LD_LW:   o_ld_data = i_rdata;
            LD_LBU:  o_ld_data = {24'h000000, w_byte};
            LD_LHU:  o_ld_data = {16'h0000, w_half};
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access.sv
// -----------------------------------------------------------------------------
// dmem_access
// Memory-stage access controller. Turns the pipeline's load/store request
// into a single bus transaction, stalls the pipeline until it finishes and
// returns the formatted load result.
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active low
//   me_writeMem  store size (00 none, 01 byte, 10 half, 11 word)
//   me_readMem   load type (000 none, LB, LH, LW, LBU, LHU; 110/111 none)
//   me_outAlu    byte address of the access
//   me_rs2Data   store data, right-aligned
//   stall        holds the upstream pipeline while an access is incomplete
//   me_memOut    registered load result (zero after store/fault)
//   misaligned   one-cycle pulse, misaligned access dropped without bus use
//   bus_err      one-cycle pulse, no ack within ACK_TIMEOUT cycles
//   dmem         data-memory bus, master side
// -----------------------------------------------------------------------------
module dmem_access
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   me_writeMem,
    input  logic [2:0]   me_readMem,
    input  logic [31:0]  me_outAlu,
    input  logic [31:0]  me_rs2Data,
    output logic         stall,
    output logic [31:0]  me_memOut,
    output logic         misaligned,
    output logic         bus_err,
    dmem_access_if.master dmem
);

    // Five bits cover the default range; widen only when the limit needs it
    localparam int CNT_W = (ACK_TIMEOUT > 32) ? 8 : 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;

    // Request captured on entry to REQ so the bus sees stable values
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_we;
    logic [2:0]        r_ld_type;
    logic [1:0]        r_ld_offset;

    logic [31:0]       r_mem_out;
    logic              r_misaligned;
    logic              r_bus_err;

    logic              w_is_store;
    logic              w_is_load;
    logic              w_access;
    logic              w_misalign;
    logic              w_start;
    logic              w_fault_mis;
    logic              w_timeout;
    logic              w_complete;
    logic              w_req;
    logic              w_stall;

    logic [31:0]       w_fmt_wdata;
    logic [3:0]        w_fmt_wstrb;
    logic [31:0]       w_fmt_ld;

    // A store wins over a simultaneous load
    assign w_is_store  = (me_writeMem != ST_NONE);
    assign w_is_load   = !w_is_store && ld_valid(me_readMem);
    assign w_access    = w_is_store || w_is_load;
    assign w_misalign  = is_misaligned(me_writeMem, me_readMem, me_outAlu[1:0]);

    assign w_start     = (r_state == S_IDLE) && w_access && !w_misalign;
    assign w_fault_mis = (r_state == S_IDLE) && w_access && w_misalign;
    // Ack is only meaningful while a request is on the bus
    assign w_complete  = (r_state == S_REQ) && dmem.dmem_ack;
    assign w_timeout   = (r_state == S_REQ) && !dmem.dmem_ack && (r_cnt == CNT_LAST);

    dmem_format u_format (
        .i_st_size   (me_writeMem),
        .i_st_offset (me_outAlu[1:0]),
        .i_st_data   (me_rs2Data),
        .i_ld_type   (r_ld_type),
        .i_ld_offset (r_ld_offset),
        .i_rdata     (dmem.dmem_rdata),
        .o_wdata     (w_fmt_wdata),
        .o_wstrb     (w_fmt_wstrb),
        .o_ld_data   (w_fmt_ld)
    );

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM next state and outputs ----------------
    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_access;
                if (w_access) begin
                    w_next = w_misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                w_req   = 1'b1;
                w_stall = w_access;
                if (dmem.dmem_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Stall releases here so the pipeline moves on this cycle
                w_stall = 1'b0;
                w_next  = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- Ack-wait counter ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ) begin
            if (!dmem.dmem_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // ---------------- Control and result registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_mem_out    <= '0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_start) begin
                r_we <= w_is_store;
            end
            // A store carries LD_NONE, which formats to zero
            if (w_complete) begin
                r_mem_out <= w_fmt_ld;
            end else if (w_timeout || w_fault_mis) begin
                r_mem_out <= '0;
            end
            // Both pulses are set on the transition into DONE only
            r_misaligned <= w_fault_mis;
            r_bus_err    <= w_timeout;
        end
    end

    // ---------------- Captured request data ----------------
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_addr      <= {me_outAlu[31:2], 2'b00};
            r_wdata     <= w_is_store ? w_fmt_wdata : 32'h0;
            r_wstrb     <= w_is_store ? w_fmt_wstrb : 4'h0;
            r_ld_type   <= w_is_store ? 3'(LD_NONE) : me_readMem;
            r_ld_offset <= me_outAlu[1:0];
        end
    end

    assign stall           = w_stall;
    assign me_memOut       = r_mem_out;
    assign misaligned      = r_misaligned;
    assign bus_err         = r_bus_err;

    assign dmem.dmem_req   = w_req;
    assign dmem.dmem_we    = w_req && r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wstrb = r_wstrb;

endmodule

// File: tb/tb_dmem_access.sv
// -----------------------------------------------------------------------------
// tb_dmem_access
// Directed bench for dmem_access with a hand-driven memory responder.
// -----------------------------------------------------------------------------
module tb_dmem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  me_writeMem;
    logic [2:0]  me_readMem;
    logic [31:0] me_outAlu;
    logic [31:0] me_rs2Data;
    logic        stall;
    logic [31:0] me_memOut;
    logic        misaligned;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    dmem_access_if dmem ();

    dmem_access #(.ACK_TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .me_writeMem (me_writeMem),
        .me_readMem  (me_readMem),
        .me_outAlu   (me_outAlu),
        .me_rs2Data  (me_rs2Data),
        .stall       (stall),
        .me_memOut   (me_memOut),
        .misaligned  (misaligned),
        .bus_err     (bus_err),
        .dmem        (dmem)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        me_writeMem     = 2'b00;
        me_readMem      = 3'b000;
        me_outAlu       = 32'h0;
        me_rs2Data      = 32'h0;
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = 32'h0;
    endtask

    // Issue a load, ack it in the first REQ cycle, then return to IDLE
    task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        me_readMem = t;
        me_outAlu  = a;
        tick;
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = rd;
        tick;
        idle_inputs;
        tick;
    endtask

    task automatic test_reset;
        idle_inputs;
        rst = 1'b0;
        repeat (3) tick;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
        checks++; if (dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", dmem.dmem_req); end
        checks++; if (dmem.dmem_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", dmem.dmem_we); end
        checks++; if (me_memOut !== 32'h0) begin failures++; $display("FAIL rst_memOut got=%h exp=00000000", me_memOut); end
        checks++; if (misaligned !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL rst_faults got=%b%b exp=00", misaligned, bus_err); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_sw;
        int sc;
        sc = 0;
        me_writeMem = 2'b11;
        me_outAlu   = 32'h104;
        me_rs2Data  = 32'hDEADBEEF;
        #1;
        if (stall === 1'b1) sc++;
        checks++; if (dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL sw_idle_req got=%b exp=0", dmem.dmem_req); end
        tick;
        if (stall === 1'b1) sc++;
        checks++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_we !== 1'b1) begin failures++; $display("FAIL sw_req_we got=%b%b exp=11", dmem.dmem_req, dmem.dmem_we); end
        checks++; if (dmem.dmem_addr !== 32'h104) begin failures++; $display("FAIL sw_addr got=%h exp=00000104", dmem.dmem_addr); end
        checks++; if (dmem.dmem_wstrb !== 4'b1111) begin failures++; $display("FAIL sw_wstrb got=%b exp=1111", dmem.dmem_wstrb); end
        checks++; if (dmem.dmem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", dmem.dmem_wdata); end
        dmem.dmem_ack = 1'b1;
        tick;
        if (stall === 1'b1) sc++;
        checks++; if (sc !== 2) begin failures++; $display("FAIL sw_stall_cycles got=%0d exp=2", sc); end
        checks++; if (dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL sw_done_req got=%b exp=0", dmem.dmem_req); end
        checks++; if (me_memOut !== 32'h0) begin failures++; $display("FAIL sw_memOut got=%h exp=00000000", me_memOut); end
        idle_inputs;
        tick;
    endtask

    task automatic test_loads;
        run_load(3'b001, 32'h103, 32'h80FF0000);
        checks++; if (me_memOut !== 32'hFFFFFF80) begin failures++; $display("FAIL lb got=%h exp=ffffff80", me_memOut); end
        run_load(3'b100, 32'h103, 32'h80FF0000);
        checks++; if (me_memOut !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", me_memOut); end
        run_load(3'b010, 32'h102, 32'h80FF0000);
        checks++; if (me_memOut !== 32'hFFFF80FF) begin failures++; $display("FAIL lh got=%h exp=ffff80ff", me_memOut); end
        run_load(3'b101, 32'h100, 32'h1234F00D);
        checks++; if (me_memOut !== 32'h0000F00D) begin failures++; $display("FAIL lhu got=%h exp=0000f00d", me_memOut); end
        run_load(3'b001, 32'h101, 32'h00007F00);
        checks++; if (me_memOut !== 32'h0000007F) begin failures++; $display("FAIL lb_pos got=%h exp=0000007f", me_memOut); end
        run_load(3'b011, 32'h10C, 32'hCAFEF00D);
        checks++; if (me_memOut !== 32'hCAFEF00D) begin failures++; $display("FAIL lw got=%h exp=cafef00d", me_memOut); end
    endtask

    task automatic test_misaligned;
        me_readMem = 3'b010;
        me_outAlu  = 32'h101;
        #1;
        checks++; if (stall !== 1'b1 || dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL mis_idle stall/req got=%b%b exp=10", stall, dmem.dmem_req); end
        tick;
        checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", misaligned); end
        checks++; if (dmem.dmem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL mis_done req/stall got=%b%b exp=00", dmem.dmem_req, stall); end
        checks++; if (me_memOut !== 32'h0) begin failures++; $display("FAIL mis_memOut got=%h exp=00000000", me_memOut); end
        idle_inputs;
        tick;
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", misaligned); end
        me_writeMem = 2'b11;
        me_outAlu   = 32'h106;
        tick;
        checks++; if (misaligned !== 1'b1 || dmem.dmem_req !== 1'b0) begin failures++; $display("FAIL mis_sw mis/req got=%b%b exp=10", misaligned, dmem.dmem_req); end
        idle_inputs;
        tick;
    endtask

    task automatic test_timeout;
        int n;
        run_load(3'b011, 32'h20, 32'h55AA55AA);
        checks++; if (me_memOut !== 32'h55AA55AA) begin failures++; $display("FAIL to_pre got=%h exp=55aa55aa", me_memOut); end
        me_readMem = 3'b011;
        me_outAlu  = 32'h200;
        tick;
        n = 0;
        while (dmem.dmem_req === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL to_req_cycles got=%0d exp=16", n); end
        checks++; if (bus_err !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL to_done err/stall got=%b%b exp=10", bus_err, stall); end
        checks++; if (me_memOut !== 32'h0) begin failures++; $display("FAIL to_memOut got=%h exp=00000000", me_memOut); end
        idle_inputs;
        tick;
        checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", bus_err); end
    endtask

    task automatic test_store_lanes;
        run_load(3'b011, 32'h30, 32'h01020304);
        me_writeMem = 2'b01;
        me_readMem  = 3'b011;
        me_outAlu   = 32'h2;
        me_rs2Data  = 32'h12345678;
        tick;
        checks++; if (dmem.dmem_wstrb !== 4'b0100) begin failures++; $display("FAIL sb_wstrb got=%b exp=0100", dmem.dmem_wstrb); end
        checks++; if (dmem.dmem_wdata !== 32'h78787878) begin failures++; $display("FAIL sb_wdata got=%h exp=78787878", dmem.dmem_wdata); end
        checks++; if (dmem.dmem_we !== 1'b1 || dmem.dmem_addr !== 32'h0) begin failures++; $display("FAIL sb_we_addr got=%b %h exp=1 00000000", dmem.dmem_we, dmem.dmem_addr); end
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'hFFFFFFFF;
        tick;
        checks++; if (me_memOut !== 32'h0) begin failures++; $display("FAIL sb_memOut got=%h exp=00000000", me_memOut); end
        idle_inputs;
        tick;
        me_writeMem = 2'b10;
        me_outAlu   = 32'h6;
        me_rs2Data  = 32'hAAAA5678;
        tick;
        checks++; if (dmem.dmem_wstrb !== 4'b1100 || dmem.dmem_wdata !== 32'h56785678) begin failures++; $display("FAIL sh got=%b %h exp=1100 56785678", dmem.dmem_wstrb, dmem.dmem_wdata); end
        checks++; if (dmem.dmem_addr !== 32'h4) begin failures++; $display("FAIL sh_addr got=%h exp=00000004", dmem.dmem_addr); end
        dmem.dmem_ack = 1'b1;
        tick;
        idle_inputs;
        tick;
        me_writeMem = 2'b01;
        me_outAlu   = 32'h1;
        me_rs2Data  = 32'h000000AB;
        tick;
        checks++; if (dmem.dmem_wstrb !== 4'b0010 || dmem.dmem_wdata !== 32'hABABABAB) begin failures++; $display("FAIL sb1 got=%b %h exp=0010 abababab", dmem.dmem_wstrb, dmem.dmem_wdata); end
        dmem.dmem_ack = 1'b1;
        tick;
        idle_inputs;
        tick;
    endtask

    task automatic test_ack_outside_req;
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'hFFFFFFFF;
        tick;
        tick;
        checks++; if (me_memOut !== 32'h0 || stall !== 1'b0) begin failures++; $display("FAIL stray_ack memOut/stall got=%h %b exp=00000000 0", me_memOut, stall); end
        me_readMem = 3'b011;
        me_outAlu  = 32'h40;
        tick;
        checks++; if (dmem.dmem_req !== 1'b1 || me_memOut !== 32'h0) begin failures++; $display("FAIL idle_ack req/memOut got=%b %h exp=1 00000000", dmem.dmem_req, me_memOut); end
        dmem.dmem_rdata = 32'h76543210;
        tick;
        checks++; if (me_memOut !== 32'h76543210) begin failures++; $display("FAIL idle_ack_lw got=%h exp=76543210", me_memOut); end
        idle_inputs;
        tick;
    endtask

    task automatic test_reset_mid_req;
        me_readMem = 3'b011;
        me_outAlu  = 32'h300;
        tick;
        tick;
        tick;
        checks++; if (dmem.dmem_req !== 1'b1) begin failures++; $display("FAIL mid_req3 got=%b exp=1", dmem.dmem_req); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (dmem.dmem_req !== 1'b0 || dmem.dmem_we !== 1'b0) begin failures++; $display("FAIL mid_async req/we got=%b%b exp=00", dmem.dmem_req, dmem.dmem_we); end
        checks++; if (me_memOut !== 32'h0 || bus_err !== 1'b0) begin failures++; $display("FAIL mid_async memOut/err got=%h %b exp=00000000 0", me_memOut, bus_err); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dmem.dmem_req !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL mid_restart_idle req/stall got=%b%b exp=01", dmem.dmem_req, stall); end
        @(negedge clk);
        checks++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_addr !== 32'h300) begin failures++; $display("FAIL mid_restart_req got=%b %h exp=1 00000300", dmem.dmem_req, dmem.dmem_addr); end
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'h13579BDF;
        tick;
        checks++; if (me_memOut !== 32'h13579BDF || bus_err !== 1'b0) begin failures++; $display("FAIL mid_restart_lw got=%h %b exp=13579bdf 0", me_memOut, bus_err); end
        idle_inputs;
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_sw;
        test_loads;
        test_misaligned;
        test_timeout;
        test_store_lanes;
        test_ack_outside_req;
        test_reset_mid_req;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access.md
DMEM_ACCESS -- requirements
Module: dmem_access

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the maximum cycles waited for dmem_ack before aborting (range 2..255).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 me_writeMem  in  2  store size: 00 none, 01 byte, 10 half, 11 word.
REQ-005 me_readMem  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 SHALL be treated as none.
REQ-006 me_outAlu  in  32  byte address of the access.
REQ-007 me_rs2Data  in  32  store data, in the low bits.
REQ-008 stall  out  1  holds IF..EX/MEM registers while an access is incomplete.
REQ-009 dmem_req, dmem_we  out  1 each  bus request and write enable.
REQ-010 dmem_addr  out  32  word address, {me_outAlu[31:2], 2'b00}.
REQ-011 dmem_wdata  out  32; dmem_wstrb  out  4  lane-aligned store data and byte strobes.
REQ-012 dmem_ack  in  1; dmem_rdata  in  32  responder completion and read word, valid with ack.
REQ-013 me_memOut  out  32  formatted load result, registered.
REQ-014 misaligned, bus_err  out  1 each  one-cycle fault pulses.

Function
REQ-015 An access SHALL be present when me_writeMem!=00 or me_readMem is a valid load; if both are set, the store SHALL win and the load SHALL be ignored.
REQ-016 FSM states SHALL be IDLE, REQ and DONE.
REQ-017 IDLE: an aligned access SHALL go to REQ; a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL go to DONE with no bus request.
REQ-018 REQ: dmem_req SHALL be 1, and addr/we/wdata/wstrb SHALL be held constant; dmem_ack=1 SHALL go to DONE and capture me_memOut.
REQ-019 REQ: a 5-bit counter, cleared on entry, SHALL increment each cycle without ack; at count ACK_TIMEOUT-1 without ack the FSM SHALL go to DONE, drop dmem_req, and set bus_err.
REQ-020 DONE SHALL always return to IDLE after one cycle; misaligned or bus_err SHALL be high only during DONE.
REQ-021 stall SHALL be combinational: access present AND state!=DONE.
REQ-022 Minimum latency from a new access to stall low SHALL be 2 cycles (IDLE, REQ with ack), with release during the 3rd cycle (DONE).
REQ-023 Store strobes SHALL be: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
REQ-024 Store data SHALL be: byte {4{rs2[7:0]}}; half {2{rs2[15:0]}}; word rs2.
REQ-025 Loads SHALL select the lane by addr[1:0]; LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass through.
REQ-026 On store completion, misalignment or timeout, me_memOut SHALL load 0.
REQ-027 dmem_ack outside REQ SHALL be ignored.

Reset
REQ-028 Assertion SHALL immediately force IDLE, counter 0, me_memOut 0, dmem_req 0, dmem_we 0, misaligned 0 and bus_err 0, including mid-REQ.
REQ-029 The in-flight access SHALL be abandoned, and the first access after deassertion SHALL start from IDLE.

Structure
REQ-030 The mem_pkg package SHALL hold the writeMem/readMem encodings and the FSM state enum.
REQ-031 Lane alignment and extension SHALL live in the combinational sub-module dmem_format; dmem_access SHALL hold only the FSM, counter and registers.

Verification
REQ-032 SW with addr 0x104, rs2 0xDEADBEEF, and ack in the 1st REQ cycle -> wstrb 1111, wdata 0xDEADBEEF, and stall high for 2 cycles.
REQ-033 LB at addr 0x103 with rdata 0x80FF0000 -> me_memOut 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-034 LH at addr 0x101 -> misaligned pulse, no dmem_req, and me_memOut 0.
REQ-035 LW with no ack and ACK_TIMEOUT=16 -> dmem_req for 16 cycles, then bus_err for 1 cycle and stall low.
REQ-036 SB at addr 0x2 with rs2 0x12345678 plus readMem=LW -> wstrb 0100, wdata 0x78787878, and dmem_we=1.
REQ-037 rst low in the 3rd REQ cycle -> dmem_req drops asynchronously, and after release a new LW completes normally.
